// File: rtl/exhaustive_stim_gen_if.sv
// -----------------------------------------------------------------------------
// exhaustive_stim_gen_if
// Bundles the control, response and result signals of exhaustive_stim_gen.
//   start      : one-cycle pulse that begins a sweep
//   mode       : sequence order for the sweep (0 = binary, 1 = Gray)
//   abort      : terminates a running sweep
//   dut_out    : response of the circuit under test
//   pattern    : registered stimulus vector, WIDTH bits
//   busy       : high while a sweep is running
//   done       : high once a sweep has completed
//   ones_count : number of vectors for which dut_out was sampled as 1
// The master modport is the controlling side, the slave modport is the
// generator itself.
// -----------------------------------------------------------------------------
interface exhaustive_stim_gen_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic             mode;
  logic             abort;
  logic             dut_out;
  logic [WIDTH-1:0] pattern;
  logic             busy;
  logic             done;
  logic [WIDTH:0]   ones_count;

  modport master (
    output start, mode, abort, dut_out,
    input  pattern, busy, done, ones_count
  );

  modport slave (
    input  start, mode, abort, dut_out,
    output pattern, busy, done, ones_count
  );
endinterface

// File: rtl/exhaustive_stim_gen.sv
// -----------------------------------------------------------------------------
// exhaustive_stim_gen
// Walks all 2^WIDTH input vectors of a circuit under test, holding each vector
// for HOLD cycles and counting how many vectors produced dut_out = 1 on the
// last cycle of their hold window.
//   clk   : single clock, rising edge
//   reset : asynchronous, active-high reset
//   bus   : exhaustive_stim_gen_if slave modport (start, mode, abort, dut_out
//           in; pattern, busy, done, ones_count out)
// Parameters: WIDTH = stimulus width, HOLD = cycles per vector (1..65535).
// -----------------------------------------------------------------------------
module exhaustive_stim_gen #(
  parameter int WIDTH = 4,
  parameter int HOLD  = 10
) (
  input logic                 clk,
  input logic                 reset,
  exhaustive_stim_gen_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [15:0]      HOLD_LAST  = 16'(HOLD - 1);
  localparam logic [WIDTH-1:0] INDEX_LAST = {WIDTH{1'b1}};

  state_t           state_r;
  state_t           state_nxt_s;
  logic [WIDTH-1:0] index_r;
  logic [WIDTH-1:0] index_nxt_s;
  logic [15:0]      hold_cnt_r;
  logic [15:0]      hold_cnt_nxt_s;
  logic [WIDTH:0]   ones_r;
  logic [WIDTH:0]   ones_nxt_s;
  logic [WIDTH-1:0] pattern_r;
  logic [WIDTH-1:0] pattern_nxt_s;
  logic             mode_r;
  logic             mode_nxt_s;
  logic             busy_r;
  logic             done_r;
  logic             sample_s;
  logic             last_vec_s;

  // Maps a sweep index onto the vector actually driven in the latched order.
  function automatic logic [WIDTH-1:0] to_vector(input logic [WIDTH-1:0] idx,
                                                 input logic             gray);
    if (gray) begin
      return idx ^ (idx >> 1);
    end else begin
      return idx;
    end
  endfunction

  assign sample_s   = (state_r == DRIVE) && (hold_cnt_r == HOLD_LAST);
  assign last_vec_s = (index_r == INDEX_LAST);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode; abort outranks the final sample so it never reaches DONE.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.start) state_nxt_s = DRIVE;
        else           state_nxt_s = IDLE;
      end
      DRIVE: begin
        if (bus.abort)                   state_nxt_s = IDLE;
        else if (sample_s && last_vec_s) state_nxt_s = DONE;
        else                             state_nxt_s = DRIVE;
      end
      DONE: begin
        if (bus.start) state_nxt_s = DRIVE;
        else           state_nxt_s = DONE;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Datapath next values: index, hold counter, tally, latched mode, pattern.
  always_comb begin
    index_nxt_s    = index_r;
    hold_cnt_nxt_s = hold_cnt_r;
    ones_nxt_s     = ones_r;
    mode_nxt_s     = mode_r;
    pattern_nxt_s  = pattern_r;
    case (state_r)
      IDLE, DONE: begin
        if (bus.start) begin
          index_nxt_s    = {WIDTH{1'b0}};
          hold_cnt_nxt_s = 16'd0;
          ones_nxt_s     = {(WIDTH+1){1'b0}};
          mode_nxt_s     = bus.mode;
          pattern_nxt_s  = {WIDTH{1'b0}};
        end else begin
          index_nxt_s    = index_r;
        end
      end
      DRIVE: begin
        if (bus.abort) begin
          // Partial tally survives; the pending sample is dropped.
          index_nxt_s    = {WIDTH{1'b0}};
          hold_cnt_nxt_s = 16'd0;
          pattern_nxt_s  = {WIDTH{1'b0}};
        end else if (sample_s) begin
          hold_cnt_nxt_s = 16'd0;
          ones_nxt_s     = ones_r + (WIDTH+1)'(bus.dut_out);
          if (!last_vec_s) begin
            index_nxt_s   = index_r + WIDTH'(1'b1);
            pattern_nxt_s = to_vector(index_r + WIDTH'(1'b1), mode_r);
          end else begin
            // Final vector stays on the outputs while DONE.
            index_nxt_s   = index_r;
          end
        end else begin
          hold_cnt_nxt_s = hold_cnt_r + 16'd1;
        end
      end
      default: begin
        index_nxt_s = {WIDTH{1'b0}};
      end
    endcase
  end

  // Datapath and status registers; busy/done track the next state directly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      index_r    <= {WIDTH{1'b0}};
      hold_cnt_r <= 16'd0;
      ones_r     <= {(WIDTH+1){1'b0}};
      mode_r     <= 1'b0;
      pattern_r  <= {WIDTH{1'b0}};
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      index_r    <= index_nxt_s;
      hold_cnt_r <= hold_cnt_nxt_s;
      ones_r     <= ones_nxt_s;
      mode_r     <= mode_nxt_s;
      pattern_r  <= pattern_nxt_s;
      busy_r     <= (state_nxt_s == DRIVE);
      done_r     <= (state_nxt_s == DONE);
    end
  end

  assign bus.pattern    = pattern_r;
  assign bus.busy       = busy_r;
  assign bus.done       = done_r;
  assign bus.ones_count = ones_r;

endmodule

// File: tb/tb_exhaustive_stim_gen.sv
// -----------------------------------------------------------------------------
// tb_exhaustive_stim_gen
// Drives a WIDTH=4/HOLD=10 generator and a WIDTH=2/HOLD=1 generator. Expected
// vectors are queued when a sweep is launched and popped each DRIVE cycle;
// final tallies come from an independent response model.
// -----------------------------------------------------------------------------
module tb_exhaustive_stim_gen;

  logic clk = 1'b0;
  logic rst;
  logic start_s;
  logic mode_s;
  logic abort_s;
  logic sel_s;
  int   fn_s;
  int   checks = 0;
  int   errors = 0;
  int   exp_q[$];

  always #5 clk = ~clk;

  exhaustive_stim_gen_if #(.WIDTH(4)) b4_if ();
  exhaustive_stim_gen_if #(.WIDTH(2)) b2_if ();

  exhaustive_stim_gen #(.WIDTH(4), .HOLD(10)) dut4 (
    .clk   (clk),
    .reset (rst),
    .bus   (b4_if)
  );

  exhaustive_stim_gen #(.WIDTH(2), .HOLD(1)) dut2 (
    .clk   (clk),
    .reset (rst),
    .bus   (b2_if)
  );

  assign b4_if.start   = start_s & ~sel_s;
  assign b4_if.abort   = abort_s & ~sel_s;
  assign b4_if.mode    = mode_s;
  assign b4_if.dut_out = (fn_s == 0) ? 1'b1 : (fn_s == 1) ? ^b4_if.pattern : &b4_if.pattern;
  assign b2_if.start   = start_s & sel_s;
  assign b2_if.abort   = abort_s & sel_s;
  assign b2_if.mode    = mode_s;
  assign b2_if.dut_out = (fn_s == 0) ? 1'b1 : (fn_s == 1) ? ^b2_if.pattern : &b2_if.pattern;

  logic [3:0] pat_o;
  logic       busy_o;
  logic       done_o;
  logic [4:0] ones_o;
  assign pat_o  = sel_s ? {2'b00, b2_if.pattern}    : b4_if.pattern;
  assign busy_o = sel_s ? b2_if.busy                : b4_if.busy;
  assign done_o = sel_s ? b2_if.done                : b4_if.done;
  assign ones_o = sel_s ? {2'b00, b2_if.ones_count} : b4_if.ones_count;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int vec_of(input int i, input bit m);
    return m ? (i ^ (i >> 1)) : i;
  endfunction

  function automatic int resp(input int fn, input int v, input int w);
    if (fn == 0) return 1;
    else if (fn == 1) return $countones(v) % 2;
    else return (v == (1 << w) - 1) ? 1 : 0;
  endfunction

  function automatic int model_ones(input bit m, input int fn, input int w, input int n);
    int sum = 0;
    for (int i = 0; i < n; i++) sum += resp(fn, vec_of(i, m), w);
    return sum;
  endfunction

  // Launch a sweep and check ncyc DRIVE cycles; extra start pulses at ign_a/ign_b.
  task automatic run_cycles(input bit s, input bit m, input int fn, input int hold,
                            input int ncyc, input int ign_a, input int ign_b);
    sel_s  = s;
    fn_s   = fn;
    mode_s = m;
    for (int c = 0; c < ncyc; c++) exp_q.push_back(vec_of(c / hold, m));
    @(posedge clk);
    #1 start_s = 1'b1;
    @(posedge clk);
    #1 start_s = 1'b0;
    mode_s = ~m;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      start_s = 1'b0;
      if (c == 0) begin
        check("start_ones_cleared", ones_o, 0);
        check("start_done_low", done_o, 0);
      end
      check($sformatf("pattern[%0d]", c), pat_o, exp_q.pop_front());
      check($sformatf("busy[%0d]", c), busy_o, 1);
      if (c == ign_a || c == ign_b) start_s = 1'b1;
    end
  endtask

  // Checks the DONE state, then that abort is ignored there.
  task automatic check_done(input int pat, input int ones);
    @(negedge clk);
    start_s = 1'b0;
    check("done", done_o, 1);
    check("busy_in_done", busy_o, 0);
    check("last_pattern", pat_o, pat);
    check("ones_count", ones_o, ones);
    check("queue_drained", exp_q.size(), 0);
    abort_s = 1'b1;
    @(negedge clk);
    abort_s = 1'b0;
    check("done_hold", done_o, 1);
    check("pattern_hold", pat_o, pat);
    check("ones_hold", ones_o, ones);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start_s = 1'b0; mode_s = 1'b0; abort_s = 1'b0; sel_s = 1'b0; fn_s = 0;
    repeat (2) @(negedge clk);
    check("rst_pattern4", b4_if.pattern, 0);
    check("rst_busy4", b4_if.busy, 0);
    check("rst_done4", b4_if.done, 0);
    check("rst_ones4", b4_if.ones_count, 0);
    check("rst_pattern2", b2_if.pattern, 0);
    check("rst_busy2", b2_if.busy, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_after_reset_busy", busy_o, 0);
    check("idle_after_reset_done", done_o, 0);

    // Binary sweep, dut_out tied high.
    run_cycles(1'b0, 1'b0, 0, 10, 160, -1, -1);
    check_done(15, model_ones(1'b0, 0, 4, 16));

    // Gray sweep from DONE, XOR response, starts during DRIVE ignored.
    run_cycles(1'b0, 1'b1, 1, 10, 160, 37, 159);
    check_done(vec_of(15, 1'b1), model_ones(1'b1, 1, 4, 16));

    // Binary sweep, XOR response.
    run_cycles(1'b0, 1'b0, 1, 10, 160, -1, -1);
    check_done(15, model_ones(1'b0, 1, 4, 16));

    // WIDTH=2, HOLD=1, AND response.
    run_cycles(1'b1, 1'b0, 2, 1, 4, -1, -1);
    check_done(3, model_ones(1'b0, 2, 2, 4));

    // Abort on the sample cycle of vector 3: that sample is discarded.
    run_cycles(1'b0, 1'b0, 0, 10, 40, -1, -1);
    abort_s = 1'b1;
    @(negedge clk);
    check("abort_pattern", pat_o, 0);
    check("abort_busy", busy_o, 0);
    check("abort_done", done_o, 0);
    check("abort_ones", ones_o, model_ones(1'b0, 0, 4, 3));
    @(negedge clk);
    abort_s = 1'b0;
    check("abort_idle_busy", busy_o, 0);
    check("abort_idle_ones", ones_o, model_ones(1'b0, 0, 4, 3));

    // Reset in the middle of vector 5, then a fresh Gray sweep.
    run_cycles(1'b0, 1'b0, 0, 10, 55, -1, -1);
    #2 rst = 1'b1;
    #1;
    check("midrst_pattern", pat_o, 0);
    check("midrst_busy", busy_o, 0);
    check("midrst_done", done_o, 0);
    check("midrst_ones", ones_o, 0);
    @(negedge clk);
    rst = 1'b0;
    run_cycles(1'b0, 1'b1, 0, 10, 160, -1, -1);
    check_done(vec_of(15, 1'b1), model_ones(1'b1, 0, 4, 16));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
